// File: rtl/irq_pkg.sv
// Shared constants, FSM encoding and vector helper for the interrupt controller.
package irq_pkg;

  localparam int unsigned VEC_W = 10;
  localparam int unsigned ID_W  = 3;

  localparam int unsigned SRC_EXCEPT  = 0;
  localparam int unsigned SRC_SYSCALL = 1;
  localparam int unsigned SRC_PORT0   = 2;
  localparam int unsigned SRC_TIMER   = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Vector address wraps modulo 2**VEC_W.
  function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0] base,
                                                input logic [VEC_W-1:0] stride,
                                                input logic [ID_W-1:0]  id);
    logic [VEC_W-1:0] id_ext;
    id_ext = VEC_W'(id);
    return base + id_ext * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index of the lowest set request bit plus valid.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = 7
) (
  input  logic [NSRC-1:0] req,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set index is written last.
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt/exception controller with single-level (non-nested) service.
// Optional periodic timer source enabled by defining TIMER_IRQ_EN.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [VEC_W-1:0] VEC_BASE     = 10'd1000,
  parameter logic [VEC_W-1:0] VEC_STRIDE   = 10'd2,
  parameter int unsigned      NSRC         = 7,
  parameter logic [15:0]      TIMER_PERIOD = 16'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_except,
  input  logic             i_syscall,
  input  logic [3:0]       i_port,
  input  logic             s_ack,
  input  logic             s_finished,
  input  logic             s_we_mask,
  input  logic [7:0]       mask_in,
  output logic             s_interruption,
  output logic [VEC_W-1:0] dir_from_exception,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [7:0]       mask
);

  irq_state_e       state_q, state_d;
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [NSRC-1:0]  pend_set, pend_clr, eligible;
  logic [7:0]       mask_q;
  logic [3:0]       sync1_q, sync2_q, prev_q;
  logic [3:0]       port_rise;
  logic [ID_W-1:0]  id_q, id_d;
  logic [VEC_W-1:0] dir_q, dir_d;
  logic [ID_W-1:0]  enc_idx;
  logic             enc_valid;
  logic             tmr_fire;

  assign port_rise = sync2_q & ~prev_q;

`ifdef TIMER_IRQ_EN
  logic [15:0] tmr_q;
  logic        tmr_reload;

  assign tmr_reload = s_we_mask & mask_in[SRC_TIMER] & ~mask_q[SRC_TIMER];
  assign tmr_fire   = mask_q[SRC_TIMER] & (tmr_q == 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q <= TIMER_PERIOD;
    end else if (tmr_reload) begin
      tmr_q <= TIMER_PERIOD;
    end else if (mask_q[SRC_TIMER]) begin
      // Stepping 1 -> 0 is the expiry: fire and reload in the same edge.
      tmr_q <= (tmr_q <= 16'd1) ? TIMER_PERIOD : tmr_q - 16'd1;
    end
  end
`else
  assign tmr_fire = 1'b0;
`endif

  always_comb begin
    pend_set                    = '0;
    pend_set[SRC_EXCEPT]        = i_except;
    pend_set[SRC_SYSCALL]       = i_syscall;
    pend_set[SRC_PORT0 +: 4]    = port_rise;
    pend_set[SRC_TIMER]         = tmr_fire;
  end

  // Exception (source 0) is non-maskable.
  assign eligible = pending_q & {mask_q[NSRC-1:1], 1'b1};

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req   (eligible),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    dir_d    = dir_q;
    pend_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          id_d    = enc_idx;
          dir_d   = vec_addr(VEC_BASE, VEC_STRIDE, enc_idx);
          state_d = REQ;
        end
      end
      REQ: begin
        if (s_ack) begin
          pend_clr = NSRC'(1) << id_q;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (s_finished) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set wins over a same-cycle clear.
  assign pending_d = (pending_q & ~pend_clr) | pend_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= 8'h00;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      id_q      <= '0;
      dir_q     <= VEC_BASE;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sync1_q   <= i_port;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      id_q      <= id_d;
      dir_q     <= dir_d;
      if (s_we_mask) begin
        mask_q <= mask_in;
      end
    end
  end

  assign s_interruption     = (state_q == REQ);
  assign in_service         = (state_q == SERVICE);
  assign irq_id             = id_q;
  assign dir_from_exception = dir_q;
  assign mask               = mask_q;

endmodule
